// File: rtl/gate_bist_sequencer_pkg.sv
// Shared definitions for the gate BIST sequencer: reference function codes and FSM states.
package gate_bist_sequencer_pkg;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_XOR  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XNOR = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gate_bist_sequencer_ref.sv
// Combinational reference model: expected output of an N_IN-input gate of type FUNC.
module gate_ref_model
  import gate_bist_sequencer_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int FUNC = 0
) (
  input  logic [N_IN-1:0] in,
  output logic            exp
);

  always_comb begin
    exp = 1'b0;
    case (FUNC)
      GATE_AND:  exp = &in;
      GATE_OR:   exp = |in;
      GATE_XOR:  exp = ^in;
      GATE_NAND: exp = ~&in;
      GATE_NOR:  exp = ~|in;
      GATE_XNOR: exp = ~^in;
      // Unsupported codes compare against a constant 0.
      default:   exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_bist_sequencer.sv
// Exhaustive self-test sequencer: walks every input vector of a small gate, holds each for a
// settle window, and checks the sampled output against the reference function.
module gate_bist_sequencer
  import gate_bist_sequencer_pkg::*;
#(
  parameter int N_IN        = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int FUNC        = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_vec
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          exp;
  logic          window_end;
  logic          mismatch;

  gate_ref_model #(
    .N_IN (N_IN),
    .FUNC (FUNC)
  ) u_ref (
    .in  (dut_in),
    .exp (exp)
  );

  assign window_end = (hold_cnt == HOLD_LAST);
  assign mismatch   = (dut_y != exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_RUN;
            hold_cnt  <= '0;
            dut_in    <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
          end
        end
        ST_RUN: begin
          // start is deliberately ignored here so a run can never be aborted.
          if (window_end) begin
            hold_cnt <= '0;
            if (mismatch) begin
              err_count <= err_count + (N_IN + 1)'(1);
              if (err_count == '0) fail_vec <= dut_in;
            end
            if (dut_in == VEC_LAST) begin
              state  <= ST_DONE;
              dut_in <= '0;
              busy   <= 1'b0;
              done   <= 1'b1;
              pass   <= (err_count == '0) && !mismatch;
            end else begin
              dut_in <= dut_in + N_IN'(1);
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist_sequencer.sv
// Bench for gate_bist_sequencer: a 2-input AND instance (H=4) and a 3-input XOR instance (H=1),
// each driving a real or deliberately faulty gate model.
module tb_gate_bist_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic start2, start3;
  int   mode;   // 0 real gate, 1 stuck-at-0, 2 stuck-at-1, 3 inverted output

  logic [1:0] d2_in;
  logic       d2_y, d2_busy, d2_done, d2_pass;
  logic [2:0] d2_err;
  logic [1:0] d2_fail;

  logic [2:0] d3_in;
  logic       d3_y, d3_busy, d3_done, d3_pass;
  logic [3:0] d3_err;
  logic [2:0] d3_fail;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  assign d2_y = (mode == 0) ? (d2_in[0] & d2_in[1]) :
                (mode == 1) ? 1'b0 :
                (mode == 2) ? 1'b1 : ~(d2_in[0] & d2_in[1]);
  assign d3_y = (mode == 3) ? ~(d3_in[0] ^ d3_in[1] ^ d3_in[2]) : (d3_in[0] ^ d3_in[1] ^ d3_in[2]);

  gate_bist_sequencer #(.N_IN(2), .HOLD_CYCLES(4), .FUNC(0)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_in(d2_in), .dut_y(d2_y),
    .busy(d2_busy), .done(d2_done), .pass(d2_pass), .err_count(d2_err), .fail_vec(d2_fail)
  );

  gate_bist_sequencer #(.N_IN(3), .HOLD_CYCLES(1), .FUNC(2)) u_xor (
    .clk(clk), .rst_n(rst_n), .start(start3), .dut_in(d3_in), .dut_y(d3_y),
    .busy(d3_busy), .done(d3_done), .pass(d3_pass), .err_count(d3_err), .fail_vec(d3_fail)
  );

  typedef struct {
    int sel;        // 0 AND instance, 1 XOR instance
    int mode;
    int pulse_at;   // run cycle at which a stray start is pulsed, -1 for none
    int exp_pass;
    int exp_err;
    int exp_fail;
  } vec_t;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic int cur_in(input int sel);
    return sel ? int'(d3_in) : int'(d2_in);
  endfunction
  function automatic int cur_busy(input int sel);
    return sel ? int'(d3_busy) : int'(d2_busy);
  endfunction
  function automatic int cur_done(input int sel);
    return sel ? int'(d3_done) : int'(d2_done);
  endfunction
  function automatic int cur_pass(input int sel);
    return sel ? int'(d3_pass) : int'(d2_pass);
  endfunction
  function automatic int cur_err(input int sel);
    return sel ? int'(d3_err) : int'(d2_err);
  endfunction
  function automatic int cur_fail(input int sel);
    return sel ? int'(d3_fail) : int'(d2_fail);
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) start3 = v;
    else start2 = v;
  endtask

  task automatic run_seq(input vec_t v);
    int n, h, t, e;
    n = v.sel ? 3 : 2;
    h = v.sel ? 1 : 4;
    t = (1 << n) * h;
    mode = v.mode;
    @(negedge clk);
    set_start(v.sel, 1'b1);
    @(negedge clk);
    set_start(v.sel, 1'b0);
    for (int k = 0; k < t; k++) exp_q.push_back(k / h);
    for (int k = 0; k < t; k++) begin
      e = exp_q.pop_front();
      check("dut_in", cur_in(v.sel), e);
      check("done_low_in_run", cur_done(v.sel), 0);
      if (k == 0) begin
        check("busy_after_start", cur_busy(v.sel), 1);
        check("err_cleared", cur_err(v.sel), 0);
        check("fail_cleared", cur_fail(v.sel), 0);
      end
      set_start(v.sel, k == v.pulse_at);
      @(negedge clk);
    end
    set_start(v.sel, 1'b0);
    check("done", cur_done(v.sel), 1);
    check("busy_end", cur_busy(v.sel), 0);
    check("pass", cur_pass(v.sel), v.exp_pass);
    check("err_count", cur_err(v.sel), v.exp_err);
    check("fail_vec", cur_fail(v.sel), v.exp_fail);
    check("dut_in_wrap", cur_in(v.sel), 0);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{sel: 0, mode: 0, pulse_at: -1, exp_pass: 1, exp_err: 0, exp_fail: 0};
    tbl[1] = '{sel: 0, mode: 1, pulse_at: -1, exp_pass: 0, exp_err: 1, exp_fail: 3};
    tbl[2] = '{sel: 0, mode: 2, pulse_at: -1, exp_pass: 0, exp_err: 3, exp_fail: 0};
    tbl[3] = '{sel: 0, mode: 2, pulse_at: 5,  exp_pass: 0, exp_err: 3, exp_fail: 0};
    tbl[4] = '{sel: 0, mode: 0, pulse_at: 5,  exp_pass: 1, exp_err: 0, exp_fail: 0};
    tbl[5] = '{sel: 1, mode: 0, pulse_at: -1, exp_pass: 1, exp_err: 0, exp_fail: 0};
    tbl[6] = '{sel: 1, mode: 3, pulse_at: 2,  exp_pass: 0, exp_err: 8, exp_fail: 0};

    rst_n  = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    mode   = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(d2_busy), 0);
    check("rst_done", int'(d2_done), 0);
    check("rst_dut_in", int'(d2_in), 0);
    check("rst_err", int'(d3_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start", int'(d2_busy), 0);

    foreach (tbl[i]) run_seq(tbl[i]);

    // Asynchronous reset in the middle of a run, while vector 2'b10 is driven.
    mode = 0;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_run_vec", int'(d2_in), 2);
    check("mid_run_busy", int'(d2_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dut_in", int'(d2_in), 0);
    check("async_rst_busy", int'(d2_busy), 0);
    check("async_rst_done", int'(d2_done), 0);
    check("async_rst_pass", int'(d2_pass), 0);
    check("async_rst_err", int'(d2_err), 0);
    check("async_rst_fail", int'(d2_fail), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", int'(d2_busy), 0);
    run_seq(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
